// File: rtl/bram_heap_pq_if.sv
// bram_heap_pq_if: operation handshake and status bundle of the heap priority queue
interface bram_heap_pq_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CW         = 4
);
   logic                  i_op_valid;
   logic                  o_op_ready;
   logic [1:0]            i_op;
   logic [DATA_WIDTH-1:0] i_data;
   logic [DATA_WIDTH-1:0] o_top;
   logic [CW-1:0]         o_count;
   logic                  o_full;
   logic                  o_empty;
   logic                  o_err;
   modport master (output i_op_valid, i_op, i_data, input o_op_ready, o_top, o_count, o_full, o_empty, o_err);
   modport slave  (input i_op_valid, i_op, i_data, output o_op_ready, o_top, o_count, o_full, o_empty, o_err);
endinterface

// File: rtl/bram_heap_pq.sv
// bram_heap_pq: binary-heap priority queue, root in a register and one dual-port RAM per lower level
module bram_heap_pq #(
   parameter int QUEUE_SIZE = 15,
   parameter int DATA_WIDTH = 16,
   parameter bit MAX_HEAP   = 1'b1
) (
   input logic           CLK,
   input logic           RSTn,
   bram_heap_pq_if.slave bus
);
   localparam int D  = $clog2(QUEUE_SIZE + 1);
   localparam int AW = D - 1;
   localparam int LW = $clog2(D + 1);
   typedef enum logic [2:0] {IDLE, PUSH_RD, POP_LAST, SIFT_RD, WAIT, CMP_WR} state_t;
   typedef enum logic [1:0] {M_PUSH, M_POP, M_SIFT} mode_t;
   state_t                r_state, w_next;
   mode_t                 r_mode;
   logic [D-1:0]          r_count, r_bound, r_node, r_target, w_cnt_inc, w_pchild, w_cbest;
   logic [LW-1:0]         r_lvl, r_tlev, w_clvl;
   logic [DATA_WIDTH-1:0] r_root, r_cur, w_prd, w_best;
   logic [D:0]            w_c0, w_c1;
   logic                  r_err, w_acc, w_push, w_pop, w_repl, w_rej, w_empty, w_full;
   logic                  w_cbt, w_v0, w_pick1, w_swap;
   logic [LW-1:0]         w_a_lvl, w_b_lvl;
   logic [AW-1:0]         w_a_addr, w_b_addr;
   logic                  w_a_re, w_a_we, w_b_re, w_b_we;
   logic [DATA_WIDTH-1:0] w_a_wd, w_b_wd;
   logic [DATA_WIDTH-1:0] w_da [2**LW];
   logic [DATA_WIDTH-1:0] w_db [2**LW];

   function automatic logic better(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      return MAX_HEAP ? (a > b) : (a < b);
   endfunction

   function automatic logic [LW-1:0] msb(input logic [D-1:0] x);
      msb = '0;
      for (int i = 0; i < D; i++) if (x[i]) msb = LW'(i);
   endfunction

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == D'(QUEUE_SIZE));
   assign w_acc     = bus.i_op_valid & (r_state == IDLE);
   assign w_rej     = w_acc & ((bus.i_op == 2'b11) | ((bus.i_op == 2'b00) & w_full) | ((bus.i_op == 2'b01) & w_empty));
   assign w_push    = w_acc & (((bus.i_op == 2'b00) & !w_full) | ((bus.i_op == 2'b10) & w_empty));
   assign w_pop     = w_acc & (bus.i_op == 2'b01) & !w_empty;
   assign w_repl    = w_acc & (bus.i_op == 2'b10) & !w_empty;
   assign w_cnt_inc = r_count + 1'b1;
   assign w_clvl    = r_lvl + 1'b1;
   // push path: next node toward the target slot is the target's prefix one level deeper
   assign w_pchild  = r_target >> (r_tlev - r_lvl - 1'b1);
   assign w_prd     = w_da[r_lvl];
   assign w_cbt     = better(r_cur, w_prd);
   assign w_c0      = {r_node, 1'b0};
   assign w_c1      = {r_node, 1'b1};
   assign w_v0      = (w_c0 <= {1'b0, r_bound});
   assign w_pick1   = (w_c1 <= {1'b0, r_bound}) & better(w_db[w_clvl], w_da[w_clvl]);
   assign w_best    = w_pick1 ? w_db[w_clvl] : w_da[w_clvl];
   assign w_cbest   = w_pick1 ? w_c1[D-1:0] : w_c0[D-1:0];
   assign w_swap    = w_v0 & better(w_best, r_cur);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_a_lvl  = w_clvl;
      w_a_addr = '0;
      w_a_re   = 1'b0;
      w_a_we   = 1'b0;
      w_a_wd   = r_cur;
      w_b_lvl  = w_clvl;
      w_b_addr = w_c1[AW-1:0];
      w_b_re   = 1'b0;
      w_b_we   = 1'b0;
      w_b_wd   = w_best;
      case (r_state)
         IDLE:     w_next = (w_push & !w_empty) ? PUSH_RD : (w_pop & (r_count != D'(1))) ? POP_LAST : w_repl ? SIFT_RD : IDLE;
         PUSH_RD: begin
            w_a_addr = w_pchild[AW-1:0];
            w_a_re   = 1'b1;
            w_next   = WAIT;
         end
         POP_LAST: begin
            w_a_lvl  = r_tlev;
            w_a_addr = r_target[AW-1:0];
            w_a_re   = 1'b1;
            w_next   = WAIT;
         end
         SIFT_RD: begin
            w_a_addr = w_c0[AW-1:0];
            w_a_re   = w_v0;
            w_b_re   = w_v0;
            w_next   = w_v0 ? WAIT : IDLE;
         end
         WAIT:     w_next = CMP_WR;
         CMP_WR: begin
            w_a_lvl  = (r_mode == M_SIFT) ? w_clvl : r_lvl;
            w_a_addr = (r_mode == M_SIFT) ? w_cbest[AW-1:0] : r_node[AW-1:0];
            w_a_we   = (r_mode == M_PUSH) | (w_swap & (r_mode == M_SIFT));
            w_a_wd   = ((r_mode == M_SIFT) | (r_node == r_target) | w_cbt) ? r_cur : w_prd;
            w_b_lvl  = r_lvl;
            w_b_addr = r_node[AW-1:0];
            w_b_we   = w_swap & (r_mode == M_SIFT) & (r_lvl != '0);
            w_next   = (r_mode == M_PUSH) ? ((r_node != r_target) ? PUSH_RD : IDLE) :
                       ((r_mode == M_POP) | w_swap) ? SIFT_RD : IDLE;
         end
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_count  <= '0;
         r_root   <= '0;
         r_cur    <= '0;
         r_err    <= 1'b0;
         r_mode   <= M_PUSH;
         r_bound  <= '0;
         r_node   <= '0;
         r_target <= '0;
         r_lvl    <= '0;
         r_tlev   <= '0;
      end else begin
         r_err <= w_rej;
         if (w_push) begin
            r_count  <= w_cnt_inc;
            r_mode   <= M_PUSH;
            r_target <= w_cnt_inc;
            r_tlev   <= msb(w_cnt_inc);
            r_node   <= D'(1);
            r_lvl    <= '0;
            r_root   <= (w_empty | better(bus.i_data, r_root)) ? bus.i_data : r_root;
            r_cur    <= better(bus.i_data, r_root) ? r_root : bus.i_data;
         end
         if (w_pop) begin
            r_count  <= r_count - 1'b1;
            r_mode   <= M_POP;
            r_target <= r_count;
            r_tlev   <= msb(r_count);
            r_node   <= D'(1);
            r_lvl    <= '0;
         end
         if (w_repl) begin
            r_mode  <= M_SIFT;
            r_root  <= bus.i_data;
            r_cur   <= bus.i_data;
            r_bound <= r_count;
            r_node  <= D'(1);
            r_lvl   <= '0;
         end
         if (r_state == PUSH_RD) begin
            r_node <= w_pchild;
            r_lvl  <= w_clvl;
         end
         if (r_state == CMP_WR && r_mode == M_PUSH && w_cbt) r_cur <= w_prd;
         // pop: former last entry becomes the root, then sifts down over the shrunken heap
         if (r_state == CMP_WR && r_mode == M_POP) begin
            r_root  <= w_da[r_tlev];
            r_cur   <= w_da[r_tlev];
            r_mode  <= M_SIFT;
            r_bound <= r_count;
         end
         if (r_state == CMP_WR && r_mode == M_SIFT && w_swap) begin
            if (r_lvl == '0) r_root <= w_best;
            r_node <= w_cbest;
            r_lvl  <= w_clvl;
         end
      end
   end

   for (genvar l = 0; l < 2**LW; l++) begin : g_lvl
      if (l >= 1 && l < D) begin : g_ram
         logic [DATA_WIDTH-1:0] r_mem [2**l];
         logic [DATA_WIDTH-1:0] r_da, r_db;
         always_ff @(posedge CLK) begin
            if (w_a_lvl == LW'(l) && w_a_we) r_mem[w_a_addr[l-1:0]] <= w_a_wd;
            if (w_b_lvl == LW'(l) && w_b_we) r_mem[w_b_addr[l-1:0]] <= w_b_wd;
            if (w_a_lvl == LW'(l) && w_a_re) r_da <= r_mem[w_a_addr[l-1:0]];
            if (w_b_lvl == LW'(l) && w_b_re) r_db <= r_mem[w_b_addr[l-1:0]];
         end
         assign w_da[l] = r_da;
         assign w_db[l] = r_db;
      end else begin : g_none
         assign w_da[l] = '0;
         assign w_db[l] = '0;
      end
   end

   assign bus.o_op_ready = (r_state == IDLE);
   assign bus.o_top      = r_root;
   assign bus.o_count    = r_count;
   assign bus.o_full     = w_full;
   assign bus.o_empty    = w_empty;
   assign bus.o_err      = r_err;
endmodule

// File: tb/tb_bram_heap_pq.sv
// tb_bram_heap_pq: max-heap and min-heap instances driven by directed and random ops against sorted-queue models
module tb_bram_heap_pq;
   localparam int LIMIT = 3 * 4 + 2;
   logic CLK, RSTn;
   int   n_cmp = 0, n_bad = 0;
   int   mq0[$];
   int   mq1[$];

   bram_heap_pq_if #(.DATA_WIDTH(16), .CW(4)) bus0 ();
   bram_heap_pq_if #(.DATA_WIDTH(16), .CW(4)) bus1 ();

   bram_heap_pq #(.QUEUE_SIZE(15), .DATA_WIDTH(16), .MAX_HEAP(1'b1)) dut0 (.CLK(CLK), .RSTn(RSTn), .bus(bus0));
   bram_heap_pq #(.QUEUE_SIZE(15), .DATA_WIDTH(16), .MAX_HEAP(1'b0)) dut1 (.CLK(CLK), .RSTn(RSTn), .bus(bus1));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic int msize(input int u);
      return (u == 0) ? mq0.size() : mq1.size();
   endfunction
   function automatic int mtop(input int u);
      return (u == 0) ? mq0[mq0.size()-1] : mq1[0];
   endfunction
   function automatic logic [31:0] top_of(input int u);
      return (u == 0) ? 32'(bus0.o_top) : 32'(bus1.o_top);
   endfunction
   function automatic logic [31:0] cnt_of(input int u);
      return (u == 0) ? 32'(bus0.o_count) : 32'(bus1.o_count);
   endfunction
   function automatic logic rdy_of(input int u);
      return (u == 0) ? bus0.o_op_ready : bus1.o_op_ready;
   endfunction
   function automatic logic err_of(input int u);
      return (u == 0) ? bus0.o_err : bus1.o_err;
   endfunction
   function automatic logic full_of(input int u);
      return (u == 0) ? bus0.o_full : bus1.o_full;
   endfunction
   function automatic logic empty_of(input int u);
      return (u == 0) ? bus0.o_empty : bus1.o_empty;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_op(input int u, input logic [1:0] o, input logic [15:0] d);
      int   sz, n;
      logic rej;
      sz  = msize(u);
      rej = (o == 2'b11) || (o == 2'b00 && sz == 15) || (o == 2'b01 && sz == 0);
      @(negedge CLK);
      bus0.i_op = o;
      bus0.i_data = d;
      bus1.i_op = o;
      bus1.i_data = d;
      bus0.i_op_valid = (u == 0);
      bus1.i_op_valid = (u == 1);
      @(negedge CLK);
      bus0.i_op_valid = 1'b0;
      bus1.i_op_valid = 1'b0;
      chk("err_pulse", 32'(err_of(u)), 32'(rej));
      if (rej) chk("reject_ready", 32'(rdy_of(u)), 1);
      n = 1;
      while (!rdy_of(u) && n <= LIMIT) begin
         @(negedge CLK);
         n++;
      end
      chk("ready_back", 32'(rdy_of(u)), 1);
      @(negedge CLK);
      chk("err_clear", 32'(err_of(u)), 0);
      if (!rej) begin
         if (o == 2'b01 || (o == 2'b10 && sz > 0)) begin
            if (u == 0) void'(mq0.pop_back());
            else        void'(mq1.pop_front());
         end
         if (o == 2'b00 || o == 2'b10) begin
            if (u == 0) begin mq0.push_back(int'(d)); mq0.sort(); end
            else begin mq1.push_back(int'(d)); mq1.sort(); end
         end
      end
      chk("count", cnt_of(u), msize(u));
      chk("empty", 32'(empty_of(u)), 32'(msize(u) == 0));
      chk("full", 32'(full_of(u)), 32'(msize(u) == 15));
      if (msize(u) > 0) chk("top", top_of(u), mtop(u));
   endtask

   initial begin
      logic [15:0] prev;
      int          r;
      logic [1:0]  o;
      RSTn = 1'b0;
      bus0.i_op_valid = 1'b0;
      bus1.i_op_valid = 1'b0;
      bus0.i_op = 2'b00;
      bus1.i_op = 2'b00;
      bus0.i_data = '0;
      bus1.i_data = '0;
      repeat (3) @(negedge CLK);
      chk("rst_ready", 32'(bus0.o_op_ready), 1);
      chk("rst_count", 32'(bus0.o_count), 0);
      chk("rst_empty", 32'(bus0.o_empty), 1);
      chk("rst_err", 32'(bus0.o_err), 0);
      chk("rst_top", 32'(bus0.o_top), 0);
      chk("rst_ready_min", 32'(bus1.o_op_ready), 1);
      RSTn = 1'b1;
      do_op(0, 2'b00, 16'd5);
      do_op(0, 2'b00, 16'd9);
      do_op(0, 2'b00, 16'd2);
      chk("push592_top", 32'(bus0.o_top), 9);
      chk("push592_count", 32'(bus0.o_count), 3);
      chk("pop_seq0", 32'(bus0.o_top), 9);
      do_op(0, 2'b01, 16'd0);
      chk("pop_seq1", 32'(bus0.o_top), 5);
      do_op(0, 2'b01, 16'd0);
      chk("pop_seq2", 32'(bus0.o_top), 2);
      do_op(0, 2'b01, 16'd0);
      chk("pop_empty", 32'(bus0.o_empty), 1);
      do_op(0, 2'b01, 16'd0);
      chk("underflow_count", 32'(bus0.o_count), 0);
      do_op(0, 2'b11, 16'd1);
      do_op(0, 2'b00, 16'd5);
      do_op(0, 2'b00, 16'd9);
      do_op(0, 2'b00, 16'd2);
      do_op(0, 2'b10, 16'd4);
      chk("replace_top", 32'(bus0.o_top), 5);
      chk("replace_count", 32'(bus0.o_count), 3);
      repeat (3) do_op(0, 2'b01, 16'd0);
      do_op(0, 2'b10, 16'd6);
      chk("replace_empty_top", 32'(bus0.o_top), 6);
      chk("replace_empty_count", 32'(bus0.o_count), 1);
      do_op(0, 2'b01, 16'd0);
      // fill to capacity, overflow, then drain checking order
      for (int i = 0; i < 15; i++) do_op(0, 2'b00, 16'($urandom_range(0, 65535)));
      chk("fill_full", 32'(bus0.o_full), 1);
      do_op(0, 2'b00, 16'd123);
      chk("overflow_count", 32'(bus0.o_count), 15);
      for (int i = 0; i < 15; i++) begin
         prev = bus0.o_top;
         do_op(0, 2'b01, 16'd0);
         if (i < 14) chk("pop_order", 32'(bus0.o_top <= prev), 1);
      end
      do_op(1, 2'b00, 16'd7);
      do_op(1, 2'b00, 16'd3);
      do_op(1, 2'b00, 16'd3);
      do_op(1, 2'b00, 16'd8);
      chk("min_pop0", 32'(bus1.o_top), 3);
      do_op(1, 2'b01, 16'd0);
      chk("min_pop1", 32'(bus1.o_top), 3);
      do_op(1, 2'b01, 16'd0);
      chk("min_pop2", 32'(bus1.o_top), 7);
      do_op(1, 2'b01, 16'd0);
      chk("min_pop3", 32'(bus1.o_top), 8);
      do_op(1, 2'b01, 16'd0);
      chk("min_empty", 32'(bus1.o_empty), 1);
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         o = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         do_op($urandom_range(0, 1), o, 16'($urandom_range(0, 40)));
      end
      for (int i = 0; i < 5; i++) do_op(0, 2'b00, 16'($urandom_range(0, 40)));
      // reset asserted while a pop is sifting down
      @(negedge CLK);
      bus0.i_op = 2'b01;
      bus0.i_op_valid = 1'b1;
      @(negedge CLK);
      bus0.i_op_valid = 1'b0;
      repeat (3) @(negedge CLK);
      chk("midop_busy", 32'(bus0.o_op_ready), 0);
      #2 RSTn = 1'b0;
      #1;
      chk("abort_ready", 32'(bus0.o_op_ready), 1);
      chk("abort_count", 32'(bus0.o_count), 0);
      chk("abort_empty", 32'(bus0.o_empty), 1);
      mq0.delete();
      mq1.delete();
      @(negedge CLK);
      RSTn = 1'b1;
      do_op(0, 2'b00, 16'd11);
      chk("after_abort_top", 32'(bus0.o_top), 11);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
